// File: rtl/cpu_phase_controller_pkg.sv
// Shared definitions for the multi-cycle CPU phase sequencer:
// controller state encodings and the default five-phase indices.
package cpu_phase_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam int unsigned PH_IF  = 0;
  localparam int unsigned PH_ID  = 1;
  localparam int unsigned PH_EX  = 2;
  localparam int unsigned PH_MEM = 3;
  localparam int unsigned PH_WB  = 4;

endpackage

// File: rtl/cpu_phase_controller_onehot.sv
// Binary phase index to one-hot decoder. The whole vector is forced
// to zero when run_i is low so that no datapath stage is enabled
// outside of RUN. This block is purely combinational; its result is
// registered by the parent.
module cpu_phase_onehot #(
  parameter int NUM_PHASES = 5,
  parameter int PHASE_W    = 3
) (
  input  logic [PHASE_W-1:0]    phase_i,
  input  logic                  run_i,
  output logic [NUM_PHASES-1:0] onehot_o
);

  // Each bit compares the index against its own position, gated by run.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      onehot_o[i] = run_i && (phase_i == PHASE_W'(i));
    end
  end

endmodule

// File: rtl/cpu_phase_controller.sv
// Multi-cycle CPU sequencer. Steps each instruction through
// NUM_PHASES phases with per-cycle stall, skip-to-last, halt or
// single-step at instruction boundaries and a retired counter.
// Every output comes straight from a register.
module cpu_phase_controller
  import cpu_phase_controller_pkg::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int PHASE_W    = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  enable,
  input  logic                  halt_req,
  input  logic                  skip,
  output logic [1:0]            state,
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES-1:0] phase_oh,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      retired
);

  localparam logic [PHASE_W-1:0] FIRST = PHASE_W'(PH_IF);
  localparam logic [PHASE_W-1:0] LAST  = PHASE_W'(NUM_PHASES - 1);

  state_e                  state_q, state_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic                    halt_pend_q, halt_pend_d;
  logic [CNT_W-1:0]        retired_q, retired_d;
  logic                    instr_done_q, instr_done_d;
  logic [NUM_PHASES-1:0]   phase_oh_q, phase_oh_d;

  // One-hot enables are decoded from the next phase so the registered
  // copy lines up with the registered phase index.
  cpu_phase_onehot #(
    .NUM_PHASES (NUM_PHASES),
    .PHASE_W    (PHASE_W)
  ) u_onehot (
    .phase_i  (phase_d),
    .run_i    (state_d == ST_RUN),
    .onehot_o (phase_oh_d)
  );

  // Next-state logic: FSM, phase counter, halt latch and retire count.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    halt_pend_d  = halt_pend_q;
    retired_d    = retired_q;
    instr_done_d = 1'b0;
    if (phase_q > LAST) begin
      state_d     = ST_IDLE;
      phase_d     = FIRST;
      halt_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state_d     = ST_RUN;
            phase_d     = FIRST;
            halt_pend_d = halt_req;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            halt_pend_d = halt_pend_q | halt_req;
          end else if (phase_q == LAST) begin
            retired_d    = retired_q + CNT_W'(1);
            instr_done_d = 1'b1;
            phase_d      = FIRST;
            if (halt_pend_q || halt_req) begin
              state_d     = ST_HALT;
              halt_pend_d = 1'b0;
            end
          end else begin
            halt_pend_d = halt_pend_q | halt_req;
            phase_d     = skip ? LAST : phase_q + PHASE_W'(1);
          end
        end
        default: begin
          state_d     = ST_IDLE;
          phase_d     = FIRST;
          halt_pend_d = 1'b0;
        end
      endcase
    end
  end

  // State registers, cleared asynchronously whenever reset is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= FIRST;
      halt_pend_q  <= 1'b0;
      retired_q    <= '0;
      instr_done_q <= 1'b0;
      phase_oh_q   <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      halt_pend_q  <= halt_pend_d;
      retired_q    <= retired_d;
      instr_done_q <= instr_done_d;
      phase_oh_q   <= phase_oh_d;
    end
  end

  assign state      = state_q;
  assign phase      = phase_q;
  assign phase_oh   = phase_oh_q;
  assign instr_done = instr_done_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_cpu_phase_controller.sv
// Self-checking bench for cpu_phase_controller (five phases, 4-bit
// retired counter so that wrap-around is reachable). A behavioural
// model tracks what the sequencer must show and is compared against
// the DUT on every falling edge; directed sequences add literal checks.
module tb_cpu_phase_controller;

  localparam int NUM_PHASES = 5;
  localparam int PHASE_W    = 3;
  localparam int CNT_W      = 4;
  localparam int LAST       = NUM_PHASES - 1;
  localparam int CNT_MOD    = 1 << CNT_W;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic                  enable = 1'b0;
  logic                  haltReq = 1'b0;
  logic                  skip = 1'b0;
  logic [1:0]            state;
  logic [PHASE_W-1:0]    phase;
  logic [NUM_PHASES-1:0] phaseOh;
  logic                  instrDone;
  logic [CNT_W-1:0]      retired;

  int vectors = 0;
  int miscompares = 0;

  // Model view of the sequencer: 0 idle, 1 run, 2 halt.
  int mState = 0;
  int mPhase = 0;
  bit mPend = 1'b0;
  int mRetired = 0;
  bit mDone = 1'b0;

  cpu_phase_controller #(
    .NUM_PHASES (NUM_PHASES),
    .PHASE_W    (PHASE_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .enable     (enable),
    .halt_req   (haltReq),
    .skip       (skip),
    .state      (state),
    .phase      (phase),
    .phase_oh   (phaseOh),
    .instr_done (instrDone),
    .retired    (retired)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Reference behaviour: what each edge must do to the visible state,
  // expressed directly from the sequencing rules.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mState = 0; mPhase = 0; mPend = 0; mRetired = 0; mDone = 0;
    end else begin
      mDone = 0;
      if (mState != 1) begin
        if (start) begin
          mState = 1; mPhase = 0; mPend = haltReq;
        end
      end else if (!enable) begin
        mPend = mPend | haltReq;
      end else if (mPhase == LAST) begin
        mRetired = (mRetired + 1) % CNT_MOD;
        mDone = 1;
        mPhase = 0;
        if (mPend || haltReq) begin
          mState = 2; mPend = 0;
        end
      end else begin
        mPend = mPend | haltReq;
        mPhase = skip ? LAST : mPhase + 1;
      end
    end
  end

  function automatic int expectOh(int st, int ph);
    return (st == 1) ? (1 << ph) : 0;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model, away from the rising edge.
  always @(negedge clock) begin
    checkOutput("model.state", state, mState);
    checkOutput("model.phase", phase, mPhase);
    checkOutput("model.phase_oh", phaseOh, expectOh(mState, mPhase));
    checkOutput("model.instr_done", instrDone, mDone);
    checkOutput("model.retired", retired, mRetired);
  end

  task automatic applyStimulus(input bit s, input bit e, input bit h, input bit k);
    start = s; enable = e; haltReq = h; skip = k;
    @(posedge clock);
    #1;
  endtask

  // Literal expectation for both the DUT and the model.
  task automatic expectAll(input string name, input int st, input int ph, input int dn, input int ret);
    checkOutput({name, ".state"}, state, st);
    checkOutput({name, ".phase"}, phase, ph);
    checkOutput({name, ".phase_oh"}, phaseOh, expectOh(st, ph));
    checkOutput({name, ".instr_done"}, instrDone, dn);
    checkOutput({name, ".retired"}, retired, ret);
    checkOutput({name, ".model_state"}, mState, st);
    checkOutput({name, ".model_phase"}, mPhase, ph);
    checkOutput({name, ".model_retired"}, mRetired, ret);
  endtask

  task automatic pulseReset();
    #1 reset = 1'b0;
    #1;
    expectAll("async_reset", 0, 0, 0, 0);
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    applyStimulus(0, 0, 0, 0);
    expectAll("after_reset", 0, 0, 0, 0);

    // Reset in the middle of an instruction at phase 3.
    applyStimulus(1, 1, 0, 0);
    for (int p = 1; p <= 3; p++) applyStimulus(0, 1, 0, 0);
    expectAll("mid_run_ph3", 1, 3, 0, 0);
    pulseReset();
    applyStimulus(0, 0, 0, 0);
    expectAll("reset_mid_run", 0, 0, 0, 0);

    // Plain instruction: phases 0..4, then retire.
    applyStimulus(1, 1, 0, 0);
    expectAll("start_ph0", 1, 0, 0, 0);
    for (int p = 1; p <= 4; p++) begin
      applyStimulus(0, 1, 0, 0);
      expectAll($sformatf("run_ph%0d", p), 1, p, 0, 0);
    end
    applyStimulus(0, 1, 0, 0);
    expectAll("retire1", 1, 0, 1, 1);

    // Three-cycle stall at phase 2 stretches the instruction to 8 cycles.
    applyStimulus(0, 1, 0, 0);
    expectAll("done_drops", 1, 1, 0, 1);
    applyStimulus(0, 1, 0, 0);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(0, 0, 0, 0);
      expectAll("stall_ph2", 1, 2, 0, 1);
    end
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    expectAll("after_stall_ph4", 1, 4, 0, 1);
    applyStimulus(0, 1, 0, 0);
    expectAll("retire2", 1, 0, 1, 2);

    // Skip from phase 1 goes to 4; skip at 4 completes normally.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 1);
    expectAll("skip_to_last", 1, 4, 0, 2);
    applyStimulus(0, 1, 0, 1);
    expectAll("skip_at_last", 1, 0, 1, 3);

    // Single-step from idle: one instruction, then halt.
    pulseReset();
    applyStimulus(1, 1, 1, 0);
    expectAll("step_start", 1, 0, 0, 0);
    for (int p = 1; p <= 4; p++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    expectAll("step_halt", 2, 0, 1, 1);
    applyStimulus(0, 1, 0, 0);
    expectAll("halt_hold", 2, 0, 0, 1);
    applyStimulus(1, 1, 0, 0);
    expectAll("restart", 1, 0, 0, 1);
    for (int p = 1; p <= 4; p++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    expectAll("no_rearm", 1, 0, 1, 2);

    // Counter wrap: reach 15, then one more retires to 0.
    for (int n = 0; n < 13 * NUM_PHASES; n++) applyStimulus(0, 1, 0, 0);
    expectAll("retired15", 1, 0, 1, 15);
    for (int n = 0; n < NUM_PHASES; n++) applyStimulus(0, 1, 0, 0);
    expectAll("wrap", 1, 0, 1, 0);

    // Halt request mid-instruction takes effect only at the boundary.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    expectAll("halt_req_ph3", 1, 3, 0, 0);
    applyStimulus(0, 1, 0, 0);
    expectAll("halt_pending_ph4", 1, 4, 0, 0);
    applyStimulus(0, 1, 0, 0);
    expectAll("halt_at_boundary", 2, 0, 1, 1);

    // Randomised traffic against the model, with rare resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulseReset();
      end else begin
        applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);
      end
    end

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
